// File: rtl/obi_host_bridge.sv
// OBI core-to-network host bridge: decodes the core address map, forwards mapped
// requests to the network and answers unmapped ones locally with an error, in grant order.
module obi_host_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                   clk_sys_in,
    input  logic                   rst_sys_in,
    // core side
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic                   data_err_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    // network request
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [AddrWidth-1:0]   req_tgt_addr_o,
    output logic                   req_wen_o,
    output logic [DataWidth-1:0]   req_wdata_o,
    output logic [DataWidth/8-1:0] req_be_o,
    // network response
    input  logic                   resp_valid_i,
    output logic                   resp_ready_o,
    input  logic [DataWidth-1:0]   resp_rdata_i
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [PtrWidth-1:0] PtrOne   = PtrWidth'(1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    localparam logic [63:0] RamLo   = 64'h0000_0000_0010_0000;
    localparam logic [63:0] RamHi   = 64'h0000_0000_0010_FFFF;
    localparam logic [63:0] GpioLo  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] GpioHi  = 64'h0000_0000_8000_0FFF;
    localparam logic [63:0] UartLo  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] UartHi  = 64'h0000_0000_8000_1FFF;
    localparam logic [63:0] TimerLo = 64'h0000_0000_8000_2000;
    localparam logic [63:0] TimerHi = 64'h0000_0000_8000_2FFF;

    typedef enum logic [2:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_GPIO,
        REGION_UART,
        REGION_TIMER
    } region_e;

    // Tracking FIFO: one bit per outstanding transaction, 1 = answer locally with error.
    logic [Depth-1:0]     fifo_q,   fifo_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q,  count_d;

    logic                 rvalid_q, rvalid_d;
    logic                 err_q,    err_d;
    logic [DataWidth-1:0] rdata_q,  rdata_d;

    region_e              region;
    logic                 mapped;
    logic                 has_room;
    logic                 fifo_empty;
    logic                 head_err;
    logic                 push;
    logic                 pop;

    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] lo,
                                       input logic [63:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrOne;
    endfunction

    always_comb begin
        logic [63:0] addr_ext;
        addr_ext = 64'(data_addr_i);
        region   = REGION_NONE;
        if (in_window(addr_ext, RamLo, RamHi)) begin
            region = REGION_RAM;
        end else if (in_window(addr_ext, GpioLo, GpioHi)) begin
            region = REGION_GPIO;
        end else if (in_window(addr_ext, UartLo, UartHi)) begin
            region = REGION_UART;
        end else if (in_window(addr_ext, TimerLo, TimerHi)) begin
            region = REGION_TIMER;
        end
        mapped = (region != REGION_NONE);
    end

    // Handshakes. A full tracker blocks the grant even if a pop frees a slot this cycle.
    always_comb begin
        fifo_empty   = (count_q == '0);
        has_room     = (count_q < DepthCnt);
        head_err     = fifo_q[rd_ptr_q];

        req_valid_o  = data_req_i & mapped & has_room;
        data_gnt_o   = data_req_i & has_room & (req_ready_i | ~mapped);
        resp_ready_o = ~fifo_empty & ~head_err;

        push         = data_gnt_o;
        pop          = ~fifo_empty & (head_err | resp_valid_i);
    end

    assign req_tgt_addr_o = data_addr_i;
    assign req_wen_o      = data_we_i;
    assign req_wdata_o    = data_wdata_i;
    assign req_be_o       = data_be_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            fifo_d[wr_ptr_q] = ~mapped;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        rvalid_d = pop;
        err_d    = pop & head_err;
        rdata_d  = (pop && !head_err) ? resp_rdata_i : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    // NOTE: the tracker bits are reset as well; they are few, and a clean reset keeps
    // a stale error marker from ever reaching the head after a mid-transaction reset.
    always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
        if (!rst_sys_in) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_obi_host_bridge.sv
// Self-checking bench for obi_host_bridge: directed cycle checks plus an in-order
// response scoreboard filled at grant time and drained on every data_rvalid_o.
module tb_obi_host_bridge;

    logic        clk_sys_in = 1'b0;
    logic        rst_sys_in = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_rdata_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b1;
    logic [31:0] req_tgt_addr_o;
    logic        req_wen_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_be_o;
    logic        resp_valid_i = 1'b0;
    logic        resp_ready_o;
    logic [31:0] resp_rdata_i = '0;

    always #5 clk_sys_in = ~clk_sys_in;

    obi_host_bridge #(.AddrWidth(32), .DataWidth(32), .Depth(2)) dut (
        .clk_sys_in     (clk_sys_in),
        .rst_sys_in     (rst_sys_in),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_tgt_addr_o (req_tgt_addr_o),
        .req_wen_o      (req_wen_o),
        .req_wdata_o    (req_wdata_o),
        .req_be_o       (req_be_o),
        .resp_valid_i   (resp_valid_i),
        .resp_ready_o   (resp_ready_o),
        .resp_rdata_i   (resp_rdata_i)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; combinational outputs are checked 1ns later.
    task automatic next_cycle();
        @(posedge clk_sys_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic core_idle();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
    endtask

    task automatic core_drive(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        data_be_i    = be;
    endtask

    always @(negedge clk_sys_in) begin : rsp_monitor
        exp_t e;
        if (data_rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_err", {31'd0, data_err_o}, {31'd0, e.err});
                check("rsp_rdata", data_rdata_o, e.data);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not terminate");
    end

    typedef struct {
        logic [31:0] addr;
        logic        mapped;
    } dec_t;

    dec_t dec_tab[12] = '{
        '{32'h000F_FFFF, 1'b0}, '{32'h0010_0000, 1'b1}, '{32'h0010_FFFF, 1'b1},
        '{32'h0011_0000, 1'b0}, '{32'h7FFF_FFFF, 1'b0}, '{32'h8000_0000, 1'b1},
        '{32'h8000_0FFF, 1'b1}, '{32'h8000_1FFF, 1'b1}, '{32'h8000_2000, 1'b1},
        '{32'h8000_2FFF, 1'b1}, '{32'h8000_3000, 1'b0}, '{32'hFFFF_FFFF, 1'b0}
    };

    initial begin : stimulus
        // Reset state
        #2;
        check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        check("rst_err", {31'd0, data_err_o}, 32'd0);
        check("rst_rdata", data_rdata_o, 32'd0);
        check("rst_req_valid", {31'd0, req_valid_o}, 32'd0);
        check("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
        check("rst_resp_ready", {31'd0, resp_ready_o}, 32'd0);
        next_cycle();
        next_cycle();
        rst_sys_in = 1'b1;

        // Mapped read, network answers three cycles after the grant
        next_cycle();
        core_drive(1'b0, 32'h0010_0004, 32'd0, 4'hF);
        req_ready_i = 1'b1;
        settle();
        check("a_gnt", {31'd0, data_gnt_o}, 32'd1);
        check("a_req_valid", {31'd0, req_valid_o}, 32'd1);
        check("a_tgt_addr", req_tgt_addr_o, 32'h0010_0004);
        check("a_wen", {31'd0, req_wen_o}, 32'd0);
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        next_cycle();
        core_idle();
        settle();
        check("a_resp_ready", {31'd0, resp_ready_o}, 32'd1);
        check("a_rvalid_c1", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        settle();
        check("a_rvalid_c2", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'hDEAD_BEEF;
        settle();
        check("a_rvalid_c3", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'd0;
        settle();
        check("a_rvalid_c4", {31'd0, data_rvalid_o}, 32'd1);
        check("a_rdata_c4", data_rdata_o, 32'hDEAD_BEEF);
        check("a_err_c4", {31'd0, data_err_o}, 32'd0);
        next_cycle();
        settle();
        check("a_rvalid_c5", {31'd0, data_rvalid_o}, 32'd0);
        check("a_resp_ready_c5", {31'd0, resp_ready_o}, 32'd0);

        // Unmapped write is granted without network readiness and answered with an error
        next_cycle();
        core_drive(1'b1, 32'h4000_0000, 32'hCAFE_F00D, 4'hF);
        req_ready_i = 1'b0;
        settle();
        check("b_gnt", {31'd0, data_gnt_o}, 32'd1);
        check("b_req_valid", {31'd0, req_valid_o}, 32'd0);
        sb.push_back('{1'b1, 32'd0});
        next_cycle();
        core_idle();
        settle();
        check("b_req_valid_c1", {31'd0, req_valid_o}, 32'd0);
        check("b_resp_ready_c1", {31'd0, resp_ready_o}, 32'd0);
        check("b_rvalid_c1", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        settle();
        check("b_rvalid_c2", {31'd0, data_rvalid_o}, 32'd1);
        check("b_err_c2", {31'd0, data_err_o}, 32'd1);
        check("b_rdata_c2", data_rdata_o, 32'd0);
        next_cycle();
        settle();
        check("b_rvalid_c3", {31'd0, data_rvalid_o}, 32'd0);
        req_ready_i = 1'b1;

        // Error response for B waits behind A's delayed network response
        next_cycle();
        core_drive(1'b0, 32'h8000_0010, 32'd0, 4'hF);
        settle();
        check("c_gnt_a", {31'd0, data_gnt_o}, 32'd1);
        sb.push_back('{1'b0, 32'h1234_5678});
        next_cycle();
        core_drive(1'b0, 32'h9000_0000, 32'd0, 4'hF);
        settle();
        check("c_gnt_b", {31'd0, data_gnt_o}, 32'd1);
        check("c_req_valid_b", {31'd0, req_valid_o}, 32'd0);
        sb.push_back('{1'b1, 32'd0});
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            core_idle();
            if (c == 5) begin
                resp_valid_i = 1'b1;
                resp_rdata_i = 32'h1234_5678;
            end
            settle();
            check($sformatf("c_rvalid_hold_c%0d", c), {31'd0, data_rvalid_o}, 32'd0);
        end
        next_cycle();
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'd0;
        settle();
        check("c_rvalid_a", {31'd0, data_rvalid_o}, 32'd1);
        check("c_err_a", {31'd0, data_err_o}, 32'd0);
        next_cycle();
        settle();
        check("c_rvalid_b", {31'd0, data_rvalid_o}, 32'd1);
        check("c_err_b", {31'd0, data_err_o}, 32'd1);
        next_cycle();
        settle();
        check("c_rvalid_end", {31'd0, data_rvalid_o}, 32'd0);

        // Tracker full: third request to UART is held until a slot frees
        next_cycle();
        core_drive(1'b0, 32'h8000_1000, 32'd0, 4'hF);
        settle();
        check("d_gnt_1", {31'd0, data_gnt_o}, 32'd1);
        sb.push_back('{1'b0, 32'h1000_0000});
        next_cycle();
        settle();
        check("d_gnt_2", {31'd0, data_gnt_o}, 32'd1);
        sb.push_back('{1'b0, 32'h1000_0001});
        next_cycle();
        settle();
        check("d_gnt_3_full", {31'd0, data_gnt_o}, 32'd0);
        check("d_req_valid_full", {31'd0, req_valid_o}, 32'd0);
        next_cycle();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'h1000_0000;
        settle();
        check("d_gnt_3_pop_cycle", {31'd0, data_gnt_o}, 32'd0);
        check("d_resp_ready", {31'd0, resp_ready_o}, 32'd1);
        next_cycle();
        resp_valid_i = 1'b0;
        settle();
        check("d_gnt_3_after", {31'd0, data_gnt_o}, 32'd1);
        check("d_rvalid_1", {31'd0, data_rvalid_o}, 32'd1);
        sb.push_back('{1'b0, 32'h1000_0002});
        next_cycle();
        core_idle();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'h1000_0001;
        settle();
        check("d_gnt_idle", {31'd0, data_gnt_o}, 32'd0);
        next_cycle();
        resp_rdata_i = 32'h1000_0002;
        settle();
        check("d_rvalid_2", {31'd0, data_rvalid_o}, 32'd1);
        next_cycle();
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'd0;
        settle();
        check("d_rvalid_3", {31'd0, data_rvalid_o}, 32'd1);
        next_cycle();
        settle();
        check("d_rvalid_end", {31'd0, data_rvalid_o}, 32'd0);
        check("d_resp_ready_end", {31'd0, resp_ready_o}, 32'd0);

        // Network back-pressure on a mapped write
        next_cycle();
        core_drive(1'b1, 32'h8000_2004, 32'hA5A5_5A5A, 4'b0011);
        req_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("e_gnt_stall_%0d", c), {31'd0, data_gnt_o}, 32'd0);
            check($sformatf("e_req_valid_stall_%0d", c), {31'd0, req_valid_o}, 32'd1);
            next_cycle();
        end
        req_ready_i = 1'b1;
        settle();
        check("e_gnt", {31'd0, data_gnt_o}, 32'd1);
        check("e_wen", {31'd0, req_wen_o}, 32'd1);
        check("e_wdata", req_wdata_o, 32'hA5A5_5A5A);
        check("e_be", {28'd0, req_be_o}, 32'h3);
        sb.push_back('{1'b0, 32'd0});
        next_cycle();
        core_idle();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'd0;
        next_cycle();
        resp_valid_i = 1'b0;
        settle();
        check("e_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check("e_err", {31'd0, data_err_o}, 32'd0);

        // Reset with two outstanding reads, then a spurious network response
        next_cycle();
        core_drive(1'b0, 32'h0010_0010, 32'd0, 4'hF);
        next_cycle();
        core_drive(1'b0, 32'h0010_0014, 32'd0, 4'hF);
        next_cycle();
        core_idle();
        settle();
        check("f_resp_ready_pre", {31'd0, resp_ready_o}, 32'd1);
        rst_sys_in = 1'b0;
        sb.delete();
        #2;
        check("f_resp_ready_rst", {31'd0, resp_ready_o}, 32'd0);
        check("f_rvalid_rst", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        rst_sys_in = 1'b1;
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'hBAD0_BAD0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("f_resp_ready_%0d", c), {31'd0, resp_ready_o}, 32'd0);
            check($sformatf("f_rvalid_%0d", c), {31'd0, data_rvalid_o}, 32'd0);
            next_cycle();
        end
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'd0;

        // Address window edges: mapped ones wait on the network, unmapped ones are granted
        foreach (dec_tab[i]) begin
            next_cycle();
            core_drive(1'b0, dec_tab[i].addr, 32'd0, 4'hF);
            req_ready_i = 1'b0;
            settle();
            check($sformatf("dec_req_valid_%08h", dec_tab[i].addr),
                  {31'd0, req_valid_o}, {31'd0, dec_tab[i].mapped});
            check($sformatf("dec_gnt_%08h", dec_tab[i].addr),
                  {31'd0, data_gnt_o}, {31'd0, ~dec_tab[i].mapped});
            if (!dec_tab[i].mapped) begin
                sb.push_back('{1'b1, 32'd0});
            end
            next_cycle();
            core_idle();
            next_cycle();
            next_cycle();
        end
        req_ready_i = 1'b1;

        for (int c = 0; c < 4; c++) begin
            next_cycle();
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/obi_host_bridge.md
OBI_HOST_BRIDGE -- requirements
Module: obi_host_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, width of core and network addresses.
REQ-002 SHALL have parameter DataWidth, default 32, width of data; byte-enable width is DataWidth/8.
REQ-003 SHALL have parameter Depth, default 2, the maximum number of outstanding transactions.
REQ-004 clk_sys_in  input  1  clock; all state SHALL change on its rising edge.
REQ-005 rst_sys_in  input  1  reset, asynchronous, active-low.
REQ-006 data_req_i / data_we_i  input  1 / 1  core request and write enable.
REQ-007 data_be_i / data_addr_i / data_wdata_i  input  DataWidth/8 / AddrWidth / DataWidth  core byte enables, address and write data.
REQ-008 data_gnt_o / data_rvalid_o / data_err_o  output  1 / 1 / 1  core grant, response valid and error flag.
REQ-009 data_rdata_o  output  DataWidth  core response data.
REQ-010 req_valid_o / req_ready_i  output / input  1 / 1  network request handshake.
REQ-011 req_tgt_addr_o / req_wen_o / req_wdata_o / req_be_o  output  AddrWidth / 1 / DataWidth / DataWidth/8  network request payload.
REQ-012 resp_valid_i / resp_ready_o / resp_rdata_i  input / output / input  1 / 1 / DataWidth  network response handshake and data.

Function
REQ-013 Mapped address windows SHALL be: RAM 0x00100000-0x0010FFFF; GPIO 0x80000000-0x80000FFF; UART 0x80001000-0x80001FFF; TIMER 0x80002000-0x80002FFF. Every other address is unmapped.
REQ-014 A tracking FIFO of Depth entries SHALL hold one bit per outstanding transaction: 0 = network, 1 = local error. An outstanding count SHALL run 0..Depth.
REQ-015 req_valid_o SHALL equal data_req_i AND mapped AND (count < Depth). The request payload SHALL pass combinationally from the core inputs.
REQ-016 data_gnt_o SHALL equal data_req_i AND (count < Depth) AND (req_ready_i OR unmapped).
REQ-017 On a grant, the bridge SHALL push the FIFO entry for that transaction (0 if mapped, 1 if unmapped). An unmapped request SHALL never assert req_valid_o.
REQ-018 When the FIFO is non-empty and the head entry is 0, resp_ready_o SHALL be 1; otherwise resp_ready_o SHALL be 0.
REQ-019 When resp_valid_i AND resp_ready_o are high in cycle c, the FIFO head SHALL pop. In cycle c+1, data_rvalid_o SHALL be 1, data_rdata_o SHALL equal resp_rdata_i from cycle c, and data_err_o SHALL be 0.
REQ-020 When the head entry is 1 in cycle c, the FIFO head SHALL pop. In cycle c+1, data_rvalid_o SHALL be 1, data_err_o SHALL be 1 and data_rdata_o SHALL be 0.
REQ-021 Responses to the core SHALL be issued in grant order. At most one pop SHALL occur per cycle.
REQ-022 data_rvalid_o, data_err_o and data_rdata_o SHALL be registered. data_rvalid_o SHALL be high for exactly one cycle per response and SHALL otherwise be 0.
REQ-023 A push and a pop in the same cycle SHALL leave the count unchanged. When count == Depth, data_gnt_o SHALL be 0, even if a pop occurs in that cycle.
REQ-024 Every granted write SHALL also produce exactly one response (rvalid, no data). The network returns one response per accepted request.
REQ-025 resp_valid_i while resp_ready_o is 0 SHALL be ignored and SHALL NOT change state.
REQ-026 Minimum latency from grant to data_rvalid_o SHALL be 2 cycles.

Reset
REQ-027 While rst_sys_in is 0, the FIFO SHALL be emptied and the count SHALL be 0. data_rvalid_o, data_err_o and data_rdata_o SHALL be 0. Consequently req_valid_o, data_gnt_o and resp_ready_o SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL discard all outstanding entries. No response SHALL be issued after reset deasserts until a new grant occurs.

Verification
REQ-029 Read of 0x00100004 with req_ready_i=1 at cycle 0, resp_valid_i=1 and rdata 0xDEADBEEF at cycle 3 -> gnt at cycle 0; rvalid=1, rdata=0xDEADBEEF, err=0 at cycle 4.
REQ-030 Write to 0x40000000 (unmapped) -> gnt=1, req_valid_o=0 throughout; rvalid=1, err=1 two cycles after the grant.
REQ-031 Back-to-back mapped read A then unmapped read B, with A's network response delayed 5 cycles -> B's error response is issued only in the cycle after A's response.
REQ-032 Three consecutive requests to 0x80001000 with no network responses -> the first two are granted, the third is held with gnt=0. One response -> the third is granted the following cycle.
REQ-033 req_ready_i=0 for 3 cycles on a mapped request -> gnt=0 and req_valid_o=1 for those cycles; gnt=1 in the first cycle with req_ready_i=1.
REQ-034 Reset pulsed with 2 outstanding requests, then spurious resp_valid_i=1 -> resp_ready_o=0 and no rvalid is issued.
